cam_lane_aligner: RTL
=====================

CAM_LANE_ALIGNER -- requirements
Module: cam_lane_aligner

Interface
REQ-001 SHALL have parameter LANES, default 5, number of deserialised lanes (4 data lanes plus 1 sync lane per imager).
REQ-002 SHALL have parameter W, default 8, deserialisation factor in bits per lane word.
REQ-003 SHALL have parameter TRAIN, default 8'hA5, W-bit training word the imager emits during alignment.
REQ-004 SHALL have parameter MATCH_N, default 16, number of consecutive matching words required to declare a lane aligned.
REQ-005 SHALL have parameter SLIP_WAIT, default 4, number of idle cycles after each bitslip pulse before words are compared again.
REQ-006 SHALL have parameter MAX_SLIPS, default 2*W, number of bitslips per lane after which the lane is declared failed.
REQ-007 SHALL have port c, input, 1 bit: rx core clock; all logic runs on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port start, input, 1 bit: one-cycle pulse that begins alignment.
REQ-010 SHALL have port rx_locked, input, 1 bit: deserialiser PLL lock, synchronous to c.
REQ-011 SHALL have port rxd, input, LANES*W bits: lane words, with lane i at [i*W+W-1:i*W].
REQ-012 SHALL have port bitslip, output, LANES bits: per-lane bitslip request pulses to the deserialiser.
REQ-013 SHALL have port aligned, output, LANES bits: per-lane aligned flags.
REQ-014 SHALL have port failed, output, LANES bits: per-lane failure flags.
REQ-015 SHALL have port busy, output, 1 bit: high while any lane is in training.
REQ-016 SHALL have port done, output, 1 bit: high when every lane is either aligned or failed.

Function
REQ-017 Each lane SHALL run an independent FSM with states IDLE, CHECK, SLIP, WAIT, ALIGNED and FAILED.
REQ-018 A start pulse with rx_locked=1 while busy=0 SHALL, on the next cycle, move every lane to CHECK and clear that lane's match counter, slip counter, aligned bit and failed bit.
REQ-019 A start pulse arriving while busy=1, or while rx_locked=0, SHALL be ignored.
REQ-020 In CHECK, a lane word equal to TRAIN SHALL increment the match counter.
REQ-021 In CHECK, the lane SHALL go to ALIGNED on the same cycle the match counter reaches MATCH_N, i.e. after MATCH_N consecutive matches.
REQ-022 In CHECK, a mismatch SHALL clear the match counter and go to SLIP if the slip counter is below MAX_SLIPS; otherwise it SHALL go to FAILED.
REQ-023 SLIP SHALL assert bitslip[i] for exactly one cycle, increment the slip counter, and go to WAIT.
REQ-024 WAIT SHALL hold for SLIP_WAIT cycles and then return to CHECK with the match counter at 0.
REQ-025 ALIGNED and FAILED SHALL be held until the next accepted start, a loss of rx_locked, or reset; a mismatch while ALIGNED SHALL NOT change state.
REQ-026 aligned[i] SHALL equal (state==ALIGNED) and failed[i] SHALL equal (state==FAILED); both SHALL be registered outputs.
REQ-027 busy SHALL be high when any lane is in CHECK, SLIP or WAIT.
REQ-028 done SHALL equal AND over all lanes of (aligned|failed), registered.
REQ-029 rx_locked=0 in any cycle SHALL force every lane to IDLE on the next edge, clearing aligned, failed and bitslip.
REQ-030 If rx_locked=0 and start=1 occur in the same cycle, the loss of lock SHALL take priority.
REQ-031 Counter widths SHALL be sized by $clog2 of MATCH_N+1, SLIP_WAIT+1 and MAX_SLIPS+1 respectively; counters SHALL saturate and never wrap.
REQ-032 bitslip[i] SHALL never be high on two consecutive cycles.

Reset
REQ-033 While rst_n=0 every lane SHALL be in IDLE, all counters SHALL be 0, and bitslip, aligned, failed, busy and done SHALL all be 0.
REQ-034 Deassertion of rst_n SHALL NOT by itself start alignment; a start pulse is required.

Verification
REQ-035 Bench SHALL cover: all 5 lanes already presenting 8'hA5, then start -> no bitslip pulses; aligned=5'h1F, done=1 and busy=0 exactly 17 cycles after start.
REQ-036 Bench SHALL cover: lane 2 presenting A5 rotated by 3 bits, with a bitslip model that rotates by 1 per pulse -> exactly 3 bitslip[2] pulses spaced 6 cycles apart; aligned[2]=1; other lanes see no pulses.
REQ-037 Bench SHALL cover: lane 4 held at 8'h00 -> 16 pulses on bitslip[4], then failed[4]=1, done=1, aligned=5'h0F.
REQ-038 Bench SHALL cover: rx_locked dropped for 1 cycle during WAIT on lane 1 -> next cycle all FSMs in IDLE, busy=0, aligned=0; a later start re-trains all lanes from a slip count of 0.
REQ-039 Bench SHALL cover: start pulsed while busy=1 -> ignored, slip counters unchanged; rst_n asserted mid-training -> all outputs 0 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/cam_lane_aligner.sv
// Camera lane aligner.
// Each deserialised lane hunts for the imager training word by issuing
// bitslip pulses until MATCH_N consecutive training words are seen, or
// gives up after MAX_SLIPS slips. All lanes train in parallel and
// independently; busy/done summarise the whole group.
module cam_lane_aligner #(
   parameter int             LANES     = 5,
   parameter int             W         = 8,
   parameter logic [W-1:0]   TRAIN     = 8'hA5,
   parameter int             MATCH_N   = 16,
   parameter int             SLIP_WAIT = 4,
   parameter int             MAX_SLIPS = 2*W
) (
   input  logic                 c,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 rx_locked,
   input  logic [LANES*W-1:0]   rxd,
   output logic [LANES-1:0]     bitslip,
   output logic [LANES-1:0]     aligned,
   output logic [LANES-1:0]     failed,
   output logic                 busy,
   output logic                 done
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CHECK   = 3'd1;
   localparam logic [2:0] ST_SLIP    = 3'd2;
   localparam logic [2:0] ST_WAIT    = 3'd3;
   localparam logic [2:0] ST_ALIGNED = 3'd4;
   localparam logic [2:0] ST_FAILED  = 3'd5;

   localparam int MCW = $clog2(MATCH_N + 1);
   localparam int WCW = $clog2(SLIP_WAIT + 1);
   localparam int SCW = $clog2(MAX_SLIPS + 1);

   localparam logic [MCW-1:0] MATCH_LAST = MCW'(MATCH_N - 1);
   localparam logic [MCW-1:0] MATCH_FULL = MCW'(MATCH_N);
   localparam logic [WCW-1:0] WAIT_LAST  = WCW'(SLIP_WAIT - 1);
   localparam logic [SCW-1:0] SLIP_FULL  = SCW'(MAX_SLIPS);

   logic [LANES-1:0][2:0]     state, state_nxt;
   logic [LANES-1:0][MCW-1:0] match_cnt, match_nxt;
   logic [LANES-1:0][WCW-1:0] wait_cnt, wait_nxt;
   logic [LANES-1:0][SCW-1:0] slip_cnt, slip_nxt;
   logic [LANES-1:0]          slip_req, aligned_nxt, failed_nxt;
   logic                      start_ok;

   // A start only counts when the link is locked and no lane is mid-training.
   always_comb begin
      start_ok = start & rx_locked & ~busy;
   end

   // Group is busy while any lane is still searching for alignment.
   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (state[i] == ST_CHECK || state[i] == ST_SLIP || state[i] == ST_WAIT) begin
            busy = 1'b1;
         end
      end
   end

   // Per-lane next-state and counter logic; lock loss overrides everything, then start.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         state_nxt[i] = state[i];
         match_nxt[i] = match_cnt[i];
         wait_nxt[i]  = wait_cnt[i];
         slip_nxt[i]  = slip_cnt[i];
         if (!rx_locked) begin
            state_nxt[i] = ST_IDLE;
            match_nxt[i] = '0;
            wait_nxt[i]  = '0;
            slip_nxt[i]  = '0;
         end else if (start_ok) begin
            state_nxt[i] = ST_CHECK;
            match_nxt[i] = '0;
            wait_nxt[i]  = '0;
            slip_nxt[i]  = '0;
         end else begin
            case (state[i])
               ST_CHECK: begin
                  if (rxd[i*W +: W] == TRAIN) begin
                     if (match_cnt[i] == MATCH_LAST) begin
                        state_nxt[i] = ST_ALIGNED;
                        match_nxt[i] = MATCH_FULL;
                     end else if (match_cnt[i] < MATCH_FULL) begin
                        match_nxt[i] = match_cnt[i] + MCW'(1);
                     end
                  end else begin
                     match_nxt[i] = '0;
                     if (slip_cnt[i] < SLIP_FULL) begin
                        state_nxt[i] = ST_SLIP;
                     end else begin
                        state_nxt[i] = ST_FAILED;
                     end
                  end
               end
               ST_SLIP: begin
                  if (slip_cnt[i] < SLIP_FULL) begin
                     slip_nxt[i] = slip_cnt[i] + SCW'(1);
                  end
                  wait_nxt[i]  = '0;
                  state_nxt[i] = ST_WAIT;
               end
               ST_WAIT: begin
                  if (wait_cnt[i] >= WAIT_LAST) begin
                     state_nxt[i] = ST_CHECK;
                     match_nxt[i] = '0;
                     wait_nxt[i]  = '0;
                  end else begin
                     wait_nxt[i] = wait_cnt[i] + WCW'(1);
                  end
               end
               default: begin
               end
            endcase
         end
         slip_req[i]    = (state_nxt[i] == ST_SLIP);
         aligned_nxt[i] = (state_nxt[i] == ST_ALIGNED);
         failed_nxt[i]  = (state_nxt[i] == ST_FAILED);
      end
   end

   // State, counters and registered status outputs, all decoded from next state.
   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         state     <= '0;
         match_cnt <= '0;
         wait_cnt  <= '0;
         slip_cnt  <= '0;
         bitslip   <= '0;
         aligned   <= '0;
         failed    <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         match_cnt <= match_nxt;
         wait_cnt  <= wait_nxt;
         slip_cnt  <= slip_nxt;
         bitslip   <= slip_req;
         aligned   <= aligned_nxt;
         failed    <= failed_nxt;
         done      <= &(aligned_nxt | failed_nxt);
      end
   end

endmodule
